// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the accumulator ALU: holds the PC, registers ROM words
// into the IR, takes PC-relative branches on relj and runs the Start/Done program handshake.
module fetch_unit #(
  parameter int             PC_W      = 10,
  parameter int             IW        = 9,
  parameter logic [IW-1:0]  HALT_CODE = 9'h100
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [IW-1:0]   instr_i,
  input  logic            relj,
  input  logic [7:0]      rel_off,
  output logic [PC_W-1:0] instr_addr,
  output logic [IW-1:0]   mach_code,
  output logic            valid,
  output logic            Done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic [PC_W-1:0] rel_off_ext;
  logic [PC_W-1:0] branch_target;
  logic            ir_is_halt;

  // Offset is relative to the address of the word in IR, not the current PC; PC_W > 8.
  assign rel_off_ext   = {{(PC_W-8){rel_off[7]}}, rel_off};
  assign branch_target = ir_pc_q + rel_off_ext;
  assign ir_is_halt    = valid_q && (ir_q == HALT_CODE);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_pc_d = ir_pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    done_d  = done_q;

    unique case (state_q)
      ST_IDLE: begin
        pc_d    = '0;
        ir_d    = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (Start) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (ir_is_halt) begin
          state_d = ST_HALT;
          done_d  = 1'b1;
          valid_d = 1'b0;
          ir_d    = '0;
        end else if (valid_q && relj) begin
          // Taken branch: drop the sequential fetch and insert one bubble.
          pc_d    = branch_target;
          ir_d    = '0;
          valid_d = 1'b0;
        end else begin
          ir_d    = instr_i;
          ir_pc_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
        end
      end

      ST_HALT: begin
        valid_d = 1'b0;
        ir_d    = '0;
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          done_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_pc_q <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_pc_q <= ir_pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign instr_addr = pc_q;
  assign mach_code  = ir_q;
  assign valid      = valid_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a ROM array, a tiny ALU branch decoder (bit 8 set -> branch
// with offset in bits 7:0), a vector table for start/halt/restart and hand sequences.
module tb_fetch_unit;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [8:0] instr_i;
  logic       relj;
  logic [7:0] rel_off;
  logic [9:0] instr_addr;
  logic [8:0] mach_code;
  logic       valid;
  logic       Done;

  logic [8:0] rom [1024];

  int n_vec = 0;
  int n_bad = 0;

  fetch_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .instr_i    (instr_i),
    .relj       (relj),
    .rel_off    (rel_off),
    .instr_addr (instr_addr),
    .mach_code  (mach_code),
    .valid      (valid),
    .Done       (Done)
  );

  assign instr_i = rom[instr_addr];
  // The HALT word 9'h100 also decodes as a branch (offset 0), so every halt races relj.
  assign relj    = mach_code[8];
  assign rel_off = mach_code[7:0];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       rst;
    logic       start;
    logic [9:0] addr;
    logic [8:0] code;
    logic       v;
    logic       d;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic start, input logic [9:0] addr,
                              input logic [8:0] code, input logic v, input logic d);
    vec_t r;
    r.rst = rst; r.start = start; r.addr = addr; r.code = code; r.v = v; r.d = d;
    return r;
  endfunction

  task automatic step(input logic rst, input logic start);
    Reset = rst;
    Start = start;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] ea, input logic [8:0] ec,
                       input logic ev, input logic ed);
    n_vec++;
    if (instr_addr !== ea || mach_code !== ec || valid !== ev || Done !== ed) begin
      n_bad++;
      $display("FAIL %s: got addr=%0d code=%h valid=%b done=%b, expected addr=%0d code=%h valid=%b done=%b",
               name, instr_addr, mach_code, valid, Done, ea, ec, ev, ed);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
  endtask

  vec_t vecs [15];

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    clear_rom();

    // Program A: three words then HALT.
    rom[0] = 9'h010; rom[1] = 9'h020; rom[2] = 9'h030; rom[3] = 9'h100;

    vecs[0]  = mk(1, 0, 0, 9'h000, 0, 0);  // reset
    vecs[1]  = mk(0, 0, 0, 9'h000, 0, 0);  // idle
    vecs[2]  = mk(0, 1, 0, 9'h000, 0, 0);  // start edge -> RUN, no word yet
    vecs[3]  = mk(0, 0, 1, 9'h010, 1, 0);
    vecs[4]  = mk(0, 0, 2, 9'h020, 1, 0);
    vecs[5]  = mk(0, 0, 3, 9'h030, 1, 0);
    vecs[6]  = mk(0, 0, 4, 9'h100, 1, 0);  // HALT in IR, relj=1 too
    vecs[7]  = mk(0, 0, 4, 9'h000, 0, 1);  // HALT wins, PC frozen
    vecs[8]  = mk(0, 0, 4, 9'h000, 0, 1);
    vecs[9]  = mk(0, 1, 0, 9'h000, 0, 0);  // restart: Done drops same edge
    vecs[10] = mk(0, 0, 1, 9'h010, 1, 0);
    vecs[11] = mk(0, 1, 2, 9'h020, 1, 0);  // Start in RUN ignored
    vecs[12] = mk(0, 0, 3, 9'h030, 1, 0);
    vecs[13] = mk(1, 0, 0, 9'h000, 0, 0);  // reset mid-run
    vecs[14] = mk(0, 0, 0, 9'h000, 0, 0);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].start);
      check($sformatf("table[%0d]", i), vecs[i].addr, vecs[i].code, vecs[i].v, vecs[i].d);
    end

    // Backward branch: word at addr 5 branches by -3 to addr 2.
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = 9'(i + 1);
    rom[5] = 9'h1FD;
    step(1, 0);
    step(0, 1);
    check("bwd_start", 0, 9'h000, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0);
      check($sformatf("bwd_seq%0d", k), 10'(k), rom[k-1], 1, 0);
    end
    step(0, 0);
    check("bwd_bubble", 2, 9'h000, 0, 0);
    step(0, 0);
    check("bwd_target", 3, 9'h003, 1, 0);

    // Wrap-around: 1 -> 1020, 1020 +10 -> 6, 7 -> 1022, then sequential 1023 -> 0.
    clear_rom();
    rom[0] = 9'h011; rom[1] = 9'h1FB; rom[1020] = 9'h10A; rom[6] = 9'h066;
    rom[7] = 9'h1F7; rom[1022] = 9'h0AA; rom[1023] = 9'h0BB;
    step(1, 0);
    step(0, 1);
    step(0, 0); check("wrap_e1", 1, 9'h011, 1, 0);
    step(0, 0); check("wrap_e2", 2, 9'h1FB, 1, 0);
    step(0, 0); check("wrap_back", 1020, 9'h000, 0, 0);
    step(0, 0); check("wrap_e4", 1021, 9'h10A, 1, 0);
    step(0, 0); check("wrap_fwd", 6, 9'h000, 0, 0);
    step(0, 0); check("wrap_e6", 7, 9'h066, 1, 0);
    step(0, 0); check("wrap_e7", 8, 9'h1F7, 1, 0);
    step(0, 0); check("wrap_e8", 1022, 9'h000, 0, 0);
    step(0, 0); check("wrap_e9", 1023, 9'h0AA, 1, 0);
    step(0, 0); check("wrap_seq", 0, 9'h0BB, 1, 0);
    step(0, 0); check("wrap_e11", 1, 9'h011, 1, 0);

    // Reset for one edge at PC=7, then relaunch.
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = 9'(9'h020 + i);
    step(1, 0);
    step(0, 1);
    for (int k = 1; k <= 7; k++) step(0, 0);
    check("rst_pc7", 7, 9'h026, 1, 0);
    step(1, 0); check("rst_mid", 0, 9'h000, 0, 0);
    step(0, 0); check("rst_idle", 0, 9'h000, 0, 0);
    step(0, 1); check("rst_start", 0, 9'h000, 0, 0);
    step(0, 0); check("rst_first", 1, 9'h020, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
